sumador_acumulador: RTL and testbench

Parametrised, registered add/subtract unit with an internal accumulator and valid/ready handshakes on input and output. It is the sequential successor to the team's combinational 14-bit adder/subtractor. It adds accumulate modes, carry/borrow, signed overflow and zero flags, optional signed saturation, and backpressure. It sits between operand producers (register file or sequencer) and result consumers in the datapath.

---
 rtl/sumador_acumulador.sv | 92 +++++++++
 tb/tb_sumador_acumulador.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sumador_acumulador.sv
// Registered add/subtract unit with an accumulator, optional signed saturation,
// and valid/ready handshakes on both sides (one-entry output stage).
module sumador_acumulador #(
  parameter int WIDTH    = 14,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       oper,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic [WIDTH-1:0] acc
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q;
  logic [WIDTH-1:0] c_q, acc_q;
  logic             carry_q, ovf_q, zero_q;

  logic             accept;
  logic [WIDTH-1:0] acc_eff, op1;
  logic [WIDTH:0]   sum_w, diff_w;
  logic [WIDTH-1:0] raw, res_d;
  logic             carry_d, ovf_d;

  assign in_ready = (state_q == EMPTY) || out_ready;
  assign accept   = in_valid && in_ready;

  // A clear in the same cycle as an accumulate op makes that op start from zero.
  assign acc_eff = acc_clr ? '0 : acc_q;
  assign op1     = oper[1] ? acc_eff : a;
  assign sum_w   = {1'b0, op1} + {1'b0, b};
  assign diff_w  = {1'b0, op1} - {1'b0, b};

  always_comb begin
    raw     = oper[0] ? diff_w[WIDTH-1:0] : sum_w[WIDTH-1:0];
    carry_d = oper[0] ? diff_w[WIDTH] : sum_w[WIDTH];
    if (oper[0])
      ovf_d = (op1[WIDTH-1] != b[WIDTH-1]) && (raw[WIDTH-1] != op1[WIDTH-1]);
    else
      ovf_d = (op1[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != op1[WIDTH-1]);
    res_d = raw;
    if (SATURATE && ovf_d)
      res_d = op1[WIDTH-1] ? SAT_MIN : SAT_MAX;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      c_q     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      acc_q   <= '0;
    end else begin
      if (accept) begin
        state_q <= FULL;
        c_q     <= res_d;
        carry_q <= carry_d;
        ovf_q   <= ovf_d;
        zero_q  <= (res_d == '0);
      end else if (out_ready) begin
        state_q <= EMPTY;
      end
      if (accept && oper[1])
        acc_q <= res_d;
      else if (acc_clr)
        acc_q <= '0;
    end
  end

  assign out_valid = (state_q == FULL);
  assign c         = c_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign acc       = acc_q;

endmodule

// File: tb/tb_sumador_acumulador.sv
// Directed bench: a wrapping and a saturating instance share one stimulus stream.
module tb_sumador_acumulador;

  localparam int W = 14;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, out_ready, acc_clr;
  logic [W-1:0] a, b;
  logic [1:0]   oper;

  logic         rdy0, ov0, cy0, of0, z0;
  logic [W-1:0] c0, acc0;
  logic         rdy1, ov1, cy1, of1, z1;
  logic [W-1:0] c1, acc1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sumador_acumulador #(.WIDTH(W), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .a(a), .b(b),
    .oper(oper), .acc_clr(acc_clr), .out_valid(ov0), .out_ready(out_ready),
    .c(c0), .carry(cy0), .ovf(of0), .zero(z0), .acc(acc0)
  );

  sumador_acumulador #(.WIDTH(W), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .a(a), .b(b),
    .oper(oper), .acc_clr(acc_clr), .out_valid(ov1), .out_ready(out_ready),
    .c(c1), .carry(cy1), .ovf(of1), .zero(z1), .acc(acc1)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input logic clr);
    in_valid = v;
    oper     = op;
    a        = aa;
    b        = bb;
    acc_clr  = clr;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 2'b00, '0, '0, 1'b0);
    #12;
    check_val("rst_out_valid", ov0, 0);
    check_val("rst_c", c0, 0);
    check_val("rst_flags", {cy0, of0, z0}, 0);
    check_val("rst_acc", acc0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_in_ready", rdy0, 1);

    drive(1'b1, 2'b00, 14'h3FFF, 14'h0001, 1'b0);
    step;
    check_val("add_wrap_valid", ov0, 1);
    check_val("add_wrap_c", c0, 14'h0000);
    check_val("add_wrap_flags", {cy0, of0, z0}, 3'b101);

    drive(1'b1, 2'b00, 14'h1FFF, 14'h0001, 1'b0);
    step;
    check_val("add_ovf_c", c0, 14'h2000);
    check_val("add_ovf_flags", {cy0, of0, z0}, 3'b010);
    check_val("add_sat_c", c1, 14'h1FFF);
    check_val("add_sat_ovf", of1, 1);

    drive(1'b1, 2'b01, 14'h2000, 14'h0001, 1'b0);
    step;
    check_val("sub_sat_c", c1, 14'h2000);
    check_val("sub_sat_ovf", of1, 1);
    check_val("sub_wrap_c", c0, 14'h1FFF);

    drive(1'b1, 2'b01, 14'd5, 14'd7, 1'b0);
    step;
    check_val("sub_borrow_c", c0, 14'h3FFE);
    check_val("sub_borrow_flags", {cy0, of0, z0}, 3'b100);
    check_val("acc_untouched", acc0, 0);

    drive(1'b0, 2'b00, '0, '0, 1'b1);
    step;
    check_val("idle_drain", ov0, 0);
    check_val("clr_acc", acc0, 0);

    drive(1'b1, 2'b10, 14'h0, 14'd3, 1'b0);
    step;
    check_val("acc1_c", c0, 14'd3);
    check_val("acc1_acc", acc0, 14'd3);
    drive(1'b1, 2'b10, 14'h0, 14'd4, 1'b0);
    step;
    check_val("acc2_c", c0, 14'd7);
    check_val("acc2_acc", acc0, 14'd7);
    check_val("acc2_valid", ov0, 1);
    drive(1'b1, 2'b11, 14'h0, 14'd10, 1'b0);
    step;
    check_val("acc3_c", c0, 14'h3FFD);
    check_val("acc3_acc", acc0, 14'h3FFD);
    check_val("acc3_borrow", cy0, 1);

    drive(1'b1, 2'b10, 14'h0, 14'd9, 1'b1);
    step;
    check_val("clr_acc_op_acc", acc0, 14'd9);
    check_val("clr_acc_op_c", c0, 14'd9);

    // backpressure
    drive(1'b0, 2'b00, '0, '0, 1'b0);
    step;
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 14'h0100, 14'h0023, 1'b0);
    step;
    check_val("bp_first_c", c0, 14'h0123);
    check_val("bp_in_ready", rdy0, 0);
    drive(1'b1, 2'b10, 14'h0, 14'd5, 1'b0);
    step;
    check_val("bp_hold_c", c0, 14'h0123);
    check_val("bp_hold_valid", ov0, 1);
    check_val("bp_hold_acc", acc0, 14'd9);
    check_val("bp_hold_ready", rdy0, 0);
    out_ready = 1'b1;
    #1;
    check_val("bp_release_ready", rdy0, 1);
    step;
    check_val("bp_second_c", c0, 14'h000E);
    check_val("bp_second_acc", acc0, 14'h000E);
    check_val("bp_second_valid", ov0, 1);

    // async reset while FULL
    drive(1'b1, 2'b10, 14'h0, 14'h0123, 1'b1);
    step;
    check_val("pre_rst_acc", acc0, 14'h0123);
    out_ready = 1'b0;
    drive(1'b0, 2'b00, '0, '0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_valid", ov0, 0);
    check_val("arst_c", c0, 0);
    check_val("arst_acc", acc0, 0);
    check_val("arst_flags", {cy0, of0, z0}, 0);
    #2;
    rst = 1'b0;
    #1;
    check_val("arst_in_ready", rdy0, 1);
    drive(1'b1, 2'b10, 14'h0, 14'd2, 1'b0);
    step;
    check_val("post_rst_c", c0, 14'd2);
    check_val("post_rst_acc", acc0, 14'd2);
    check_val("post_rst_valid", ov0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
